// File: rtl/char_string_scanner_pkg.sv
// Shared types and default geometry for the text-string pixel scanner.
// Width helpers keep every port at least one bit wide.
package char_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_CHAR_W    = 8;
  localparam int DEF_CHAR_H    = 8;
  localparam int DEF_MAX_CHARS = 16;
  localparam int DEF_SCREEN_W  = 160;
  localparam int DEF_SCREEN_H  = 120;

  localparam int COL_W   = width_of(DEF_CHAR_W);
  localparam int ROW_W   = width_of(DEF_CHAR_H);
  localparam int IDX_W   = width_of(DEF_MAX_CHARS);
  localparam int DEF_X_W = width_of(DEF_SCREEN_W);
  localparam int DEF_Y_W = width_of(DEF_SCREEN_H);

endpackage

// File: rtl/char_string_scanner_if.sv
// Command (start/base/length) and pixel-stream signals of the string scanner.
// The scanner uses the slave view; the decoder and plot stage use the master view.
interface char_string_scanner_if
  import char_scan_pkg::*;
#(
  parameter int CHAR_W    = DEF_CHAR_W,
  parameter int CHAR_H    = DEF_CHAR_H,
  parameter int MAX_CHARS = DEF_MAX_CHARS,
  parameter int X_W       = DEF_X_W,
  parameter int Y_W       = DEF_Y_W
);
  localparam int COL_BITS = width_of(CHAR_W);
  localparam int ROW_BITS = width_of(CHAR_H);
  localparam int IDX_BITS = width_of(MAX_CHARS);

  logic                start;
  logic [X_W-1:0]      base_x;
  logic [Y_W-1:0]      base_y;
  logic [IDX_BITS:0]   length;
  logic                busy;
  logic                pix_valid;
  logic                pix_ready;
  logic [X_W-1:0]      pix_x;
  logic [Y_W-1:0]      pix_y;
  logic [COL_BITS-1:0] glyph_col;
  logic [ROW_BITS-1:0] glyph_row;
  logic [IDX_BITS-1:0] char_idx;
  logic                char_done;
  logic                done;

  modport slave (
    input  start, base_x, base_y, length, pix_ready,
    output busy, pix_valid, pix_x, pix_y, glyph_col, glyph_row, char_idx, char_done, done
  );

  modport master (
    output start, base_x, base_y, length, pix_ready,
    input  busy, pix_valid, pix_x, pix_y, glyph_col, glyph_row, char_idx, char_done, done
  );

endinterface

// File: rtl/char_string_scanner_glyph_pixel_counter.sv
// Column/row walker over one CHAR_W x CHAR_H glyph; column is the fast index.
// last_pixel flags the bottom-right pixel so the caller can step to the next glyph.
module glyph_pixel_counter
  import char_scan_pkg::*;
#(
  parameter  int CHAR_W   = DEF_CHAR_W,
  parameter  int CHAR_H   = DEF_CHAR_H,
  localparam int COL_BITS = width_of(CHAR_W),
  localparam int ROW_BITS = width_of(CHAR_H)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                clear,
  input  logic                advance,
  output logic [COL_BITS-1:0] col,
  output logic [ROW_BITS-1:0] row,
  output logic                last_pixel
);

  logic [COL_BITS-1:0] col_q, col_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic                last_col, last_row;

  assign last_col   = (col_q == COL_BITS'(CHAR_W - 1));
  assign last_row   = (row_q == ROW_BITS'(CHAR_H - 1));
  assign last_pixel = last_col && last_row;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (advance) begin
      col_d = last_col ? '0 : col_q + COL_BITS'(1);
      if (last_col) begin
        row_d = last_row ? '0 : row_q + ROW_BITS'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col = col_q;
  assign row = row_q;

endmodule

// File: rtl/char_string_scanner.sv
// Walks a string of glyphs left-to-right, one pixel coordinate per handshake.
// Coordinates are sums of registered state only, so pix_ready never reaches pix_*.
module char_string_scanner
  import char_scan_pkg::*;
#(
  parameter int CHAR_W    = DEF_CHAR_W,
  parameter int CHAR_H    = DEF_CHAR_H,
  parameter int MAX_CHARS = DEF_MAX_CHARS,
  parameter int X_W       = DEF_X_W,
  parameter int Y_W       = DEF_Y_W
) (
  input logic             clock,
  input logic             resetn,
  char_string_scanner_if.slave bus
);

  localparam int COL_BITS = width_of(CHAR_W);
  localparam int ROW_BITS = width_of(CHAR_H);
  localparam int IDX_BITS = width_of(MAX_CHARS);
  localparam int LEN_BITS = IDX_BITS + 1;

  scan_state_e state_q, state_d;

  logic [X_W-1:0]      base_x_q;
  logic [Y_W-1:0]      base_y_q;
  logic [LEN_BITS-1:0] len_q, len_clamped;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic                char_done_q, char_done_d;
  logic                latch, cnt_clear, handshake, last_pixel, last_char;
  logic [COL_BITS-1:0] col;
  logic [ROW_BITS-1:0] row;
  logic [IDX_BITS+COL_BITS-1:0] x_offset;

  glyph_pixel_counter #(
    .CHAR_W (CHAR_W),
    .CHAR_H (CHAR_H)
  ) u_pixel_counter (
    .clock      (clock),
    .resetn     (resetn),
    .clear      (cnt_clear),
    .advance    (handshake),
    .col        (col),
    .row        (row),
    .last_pixel (last_pixel)
  );

  assign len_clamped = (bus.length > LEN_BITS'(MAX_CHARS)) ? LEN_BITS'(MAX_CHARS) : bus.length;
  assign handshake   = (state_q == SCAN) && bus.pix_ready;
  assign last_char   = ((LEN_BITS'(idx_q) + LEN_BITS'(1)) == len_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    latch       = 1'b0;
    cnt_clear   = 1'b0;
    char_done_d = handshake && last_pixel;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          latch     = 1'b1;
          cnt_clear = 1'b1;
          idx_d     = '0;
          state_d   = (len_clamped == '0) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (handshake && last_pixel) begin
          if (last_char) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_BITS'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      char_done_q <= 1'b0;
      base_x_q    <= '0;
      base_y_q    <= '0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      char_done_q <= char_done_d;
      if (latch) begin
        base_x_q <= bus.base_x;
        base_y_q <= bus.base_y;
        len_q    <= len_clamped;
      end
    end
  end

  // Glyph widths are powers of two, so idx*CHAR_W + col is a plain concatenation.
  assign x_offset      = {idx_q, col};
  assign bus.pix_x     = base_x_q + X_W'(x_offset);
  assign bus.pix_y     = base_y_q + Y_W'(row);
  assign bus.glyph_col = col;
  assign bus.glyph_row = row;
  assign bus.char_idx  = idx_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.pix_valid = (state_q == SCAN);
  assign bus.done      = (state_q == DONE);
  assign bus.char_done = char_done_q;

endmodule

// File: tb/tb_char_string_scanner.sv
// Bench for char_string_scanner: table of scans plus random scans, checked each
// cycle against pixel-number arithmetic, with a mid-scan reset sequence.
module tb_char_string_scanner;
  import char_scan_pkg::*;

  localparam int CW  = 8;
  localparam int CH  = 8;
  localparam int MC  = 16;
  localparam int XW  = 8;
  localparam int YW  = 7;
  localparam int LW  = $clog2(MC) + 1;
  localparam int PPC = CW * CH;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  char_string_scanner_if #(.CHAR_W(CW), .CHAR_H(CH), .MAX_CHARS(MC), .X_W(XW), .Y_W(YW)) bus ();

  char_string_scanner #(.CHAR_W(CW), .CHAR_H(CH), .MAX_CHARS(MC), .X_W(XW), .Y_W(YW)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    int bx; int by; int len; int pct; bit glitch;
    int first_x; int first_y; int last_x; int last_y; int hs;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel number k of a string -> expected coordinates.
  task automatic model(input vec_t v, input int k, output logic [31:0] x, output logic [31:0] y,
                       output logic [31:0] col, output logic [31:0] row, output logic [31:0] idx);
    idx = k / PPC;
    row = (k / CW) % CH;
    col = k % CW;
    x   = (v.bx + int'(idx) * CW + int'(col)) % (1 << XW);
    y   = (v.by + int'(row)) % (1 << YW);
  endtask

  task automatic glitch_start();
    bus.start  = 1'b1;
    bus.base_x = XW'($urandom);
    bus.base_y = YW'($urandom);
    bus.length = LW'($urandom_range(0, 20));
  endtask

  task automatic check_outputs(input string tag, input logic busy, input logic valid,
                               input logic done, input logic cdone);
    check({tag, "_busy"}, 32'(bus.busy), 32'(busy));
    check({tag, "_valid"}, 32'(bus.pix_valid), 32'(valid));
    check({tag, "_done"}, 32'(bus.done), 32'(done));
    check({tag, "_char_done"}, 32'(bus.char_done), 32'(cdone));
  endtask

  // Entered and left at a negedge with the DUT idle.
  task automatic run_scan(input vec_t v);
    int eff_len, total, k, bound, dut_hs;
    logic cd_exp, ready;
    logic [31:0] ex, ey, ec, er, ei, fx, fy, lx, ly;
    eff_len = (v.len > MC) ? MC : v.len;
    total   = eff_len * PPC;
    k = 0; dut_hs = 0; cd_exp = 1'b0;
    bound = total * 20 + 50;
    fx = 0; fy = 0; lx = 0; ly = 0;
    bus.start     = 1'b1;
    bus.base_x    = XW'(v.bx);
    bus.base_y    = YW'(v.by);
    bus.length    = LW'(v.len);
    bus.pix_ready = 1'b0;
    @(posedge clock); @(negedge clock);
    bus.start = 1'b0;
    for (int cyc = 0; cyc <= bound; cyc++) begin
      if (cyc == bound) begin
        n_checks++; n_fail++;
        $display("FAIL scan_timeout: got %0d handshakes required %0d", k, total);
        break;
      end
      if (k < total) begin
        model(v, k, ex, ey, ec, er, ei);
        check_outputs("scan", 1'b1, 1'b1, 1'b0, cd_exp);
        check("pix_x", 32'(bus.pix_x), ex);
        check("pix_y", 32'(bus.pix_y), ey);
        check("glyph_col", 32'(bus.glyph_col), ec);
        check("glyph_row", 32'(bus.glyph_row), er);
        check("char_idx", 32'(bus.char_idx), ei);
        if (k == 0) begin fx = 32'(bus.pix_x); fy = 32'(bus.pix_y); end
        if (k == total - 1) begin lx = 32'(bus.pix_x); ly = 32'(bus.pix_y); end
        ready = ($urandom_range(0, 99) < v.pct);
        bus.pix_ready = ready;
        if (v.glitch) glitch_start();
        if (bus.pix_valid && ready) dut_hs++;
        if (ready) begin
          k++;
          cd_exp = (k % PPC == 0);
        end else begin
          cd_exp = 1'b0;
        end
      end else begin
        check_outputs("done_cycle", 1'b1, 1'b0, 1'b1, total > 0);
        if (v.glitch) glitch_start();
        @(posedge clock); @(negedge clock);
        bus.start = 1'b0;
        check_outputs("after_done", 1'b0, 1'b0, 1'b0, 1'b0);
        break;
      end
      @(posedge clock); @(negedge clock);
    end
    check("handshakes", 32'(dut_hs), 32'(v.hs));
    if (v.hs > 0) begin
      check("first_x", fx, 32'(v.first_x));
      check("first_y", fy, 32'(v.first_y));
      check("last_x", lx, 32'(v.last_x));
      check("last_y", ly, 32'(v.last_y));
    end
    $display("scan bx=%0d by=%0d len=%0d ready%%=%0d glitch=%0d handshakes=%0d",
             v.bx, v.by, v.len, v.pct, v.glitch, dut_hs);
  endtask

  vec_t vecs[6];

  initial begin
    vec_t rv;
    int   eff;
    vecs[0] = '{10, 20, 2, 100, 1'b0, 10, 20, 25, 27, 128};
    vecs[1] = '{5, 3, 0, 100, 1'b1, 0, 0, 0, 0, 0};
    vecs[2] = '{40, 50, 3, 50, 1'b0, 40, 50, 63, 57, 192};
    vecs[3] = '{0, 0, 20, 100, 1'b0, 0, 0, 127, 7, 1024};
    vecs[4] = '{250, 100, 1, 100, 1'b0, 250, 100, 1, 107, 64};
    vecs[5] = '{100, 124, 1, 60, 1'b1, 100, 124, 107, 3, 64};

    resetn = 1'b0;
    bus.start = 1'b0; bus.base_x = '0; bus.base_y = '0; bus.length = '0; bus.pix_ready = 1'b0;
    #12;
    check_outputs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_pix_x", 32'(bus.pix_x), 32'd0);
    check("reset_pix_y", 32'(bus.pix_y), 32'd0);
    check("reset_idx", 32'(bus.char_idx), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check_outputs("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) run_scan(vecs[i]);

    for (int r = 0; r < 5; r++) begin
      rv.bx = $urandom_range(0, 255);
      rv.by = $urandom_range(0, 127);
      rv.len = $urandom_range(0, 18);
      rv.pct = $urandom_range(30, 100);
      rv.glitch = 1'($urandom_range(0, 1));
      eff = (rv.len > MC) ? MC : rv.len;
      rv.hs = eff * PPC;
      rv.first_x = rv.bx;
      rv.first_y = rv.by;
      rv.last_x = (rv.bx + eff * CW - 1) % 256;
      rv.last_y = (rv.by + CH - 1) % 128;
      run_scan(rv);
    end

    // Reset in the middle of a scan: asynchronous clear, no done pulse.
    bus.start = 1'b1; bus.base_x = 8'd10; bus.base_y = 7'd20; bus.length = LW'(2);
    bus.pix_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    bus.start = 1'b0;
    repeat (30) @(negedge clock);
    check("midscan_busy", 32'(bus.busy), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check_outputs("async_clear", 1'b0, 1'b0, 1'b0, 1'b0);
    check("async_pix_x", 32'(bus.pix_x), 32'd0);
    check("async_pix_y", 32'(bus.pix_y), 32'd0);
    check("async_col", 32'(bus.glyph_col), 32'd0);
    check("async_idx", 32'(bus.char_idx), 32'd0);
    @(negedge clock);
    check_outputs("in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    @(negedge clock);
    check_outputs("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);

    // Fresh scan after reset, with start re-pulsed through busy and DONE.
    rv = '{33, 60, 1, 70, 1'b1, 33, 60, 40, 67, 64};
    run_scan(rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
